// File: rtl/serial_add_unit.sv
// Bit-serial adder: one full-adder cell with a registered carry loop.
// A small controller streams two operands LSB-first and assembles the result.

module full_adder (
    output logic s,
    output logic c,
    input  logic x,
    input  logic y,
    input  logic z
);
    assign s = x ^ y ^ z;
    assign c = (x & y) | (z & (x ^ y));
endmodule

module serial_add_unit #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);
    // One extra bit on power-of-two widths so the count never wraps mid-operation.
    localparam int CW = $clog2(WIDTH) + (((WIDTH & (WIDTH - 1)) == 0) ? 1 : 0);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] sa;
    logic [WIDTH-1:0] sb;
    logic [WIDTH-1:0] result;
    logic [CW-1:0]    cnt;
    logic             carry;
    logic             fa_s;
    logic             fa_c;

    full_adder u_fa (
        .s (fa_s),
        .c (fa_c),
        .x (sa[0]),
        .y (sb[0]),
        .z (carry)
    );

    // NOTE: non-blocking assignments throughout, so every register samples
    // pre-edge values and the cell's s/c pair is consumed consistently.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the datapath registers are few and tiny, so they are reset
            // too; no stale operand bits can leak into a result after an abort.
            state  <= IDLE;
            sa     <= '0;
            sb     <= '0;
            result <= '0;
            cnt    <= '0;
            carry  <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
            sum    <= '0;
            cout   <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        sa    <= a;
                        sb    <= b;
                        carry <= cin;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= SHIFT;
                    end else begin
                        state <= IDLE;
                    end
                end
                SHIFT: begin
                    carry  <= fa_c;
                    result <= {fa_s, result[WIDTH-1:1]};
                    sa     <= sa >> 1;
                    sb     <= sb >> 1;
                    cnt    <= cnt + 1'b1;
                    if (cnt == CW'(WIDTH - 1)) begin
                        sum   <= {fa_s, result[WIDTH-1:1]};
                        cout  <= fa_c;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_serial_add_unit.sv
// Self-checking bench for serial_add_unit: directed cases plus random
// operands checked against an arithmetic model with cycle-exact timing.

module tb_serial_add_unit;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;

    int checks = 0;
    int errors = 0;

    logic [W-1:0] exp_sum  = '0;
    logic         exp_cout = 1'b0;

    serial_add_unit #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Idle cycles: nothing running, result held.
    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            check("idle_busy", busy, 0);
            check("idle_done", done, 0);
            check("idle_sum", sum, exp_sum);
            check("idle_cout", cout, exp_cout);
        end
    endtask

    // Called at a negedge; returns at the negedge of the done cycle.
    // hold keeps start and operands asserted; poke re-asserts start with
    // different operands during the given busy cycle (0 = never).
    task automatic run_op(input logic [W-1:0] av, input logic [W-1:0] bv,
                          input logic ci, input bit hold, input int poke);
        logic [W:0] total;
        total = (W+1)'(av) + (W+1)'(bv) + (W+1)'(ci);
        a = av; b = bv; cin = ci; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        if (!hold) begin
            start = 1'b0;
            a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
        end
        for (int i = 1; i <= W; i++) begin
            if (i > 1) @(negedge clk);
            if (!hold) begin
                if (i == poke) begin
                    start = 1'b1; a = 8'h11; b = 8'h11; cin = 1'b0;
                end else begin
                    start = 1'b0;
                end
            end
            check("busy_high", busy, 1);
            check("done_early", done, 0);
            check("sum_held", sum, exp_sum);
            check("cout_held", cout, exp_cout);
        end
        @(negedge clk);
        if (!hold) start = 1'b0;
        exp_sum  = total[W-1:0];
        exp_cout = total[W];
        check("done_pulse", done, 1);
        check("busy_low", busy, 0);
        check("sum", sum, exp_sum);
        check("cout", cout, exp_cout);
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; a = '0; b = '0; cin = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_sum", sum, 0);
        check("rst_cout", cout, 0);
        rst_n = 1'b1;

        // First start honoured on the edge right after reset release.
        run_op(8'h00, 8'h00, 1'b0, 1'b0, 0);
        idle(2);
        run_op(8'hFF, 8'h01, 1'b0, 1'b0, 0);
        idle(1);
        run_op(8'hA5, 8'h5A, 1'b1, 1'b0, 0);
        idle(1);
        run_op(8'h3C, 8'h0F, 1'b0, 1'b0, 0);

        // Start during SHIFT is ignored; no second done follows.
        idle(1);
        run_op(8'h27, 8'h19, 1'b1, 1'b0, 3);
        idle(W + 3);

        // Start held high: back-to-back from DONE.
        idle(1);
        for (int k = 0; k < 3; k++) run_op(8'h01, 8'h02, 1'b0, 1'b1, 0);
        start = 1'b0;
        idle(1);

        // Random operands with random gaps (0 = accepted straight from DONE).
        for (int k = 0; k < 24; k++) begin
            idle(int'($urandom_range(0, 2)));
            run_op(W'($urandom), W'($urandom), 1'($urandom), 1'b0, 0);
        end

        // Asynchronous reset mid-SHIFT aborts with no done pulse.
        run_op(8'hC3, 8'h7E, 1'b1, 1'b0, 0);
        idle(1);
        a = 8'h12; b = 8'h34; cin = 1'b0; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        exp_sum = '0; exp_cout = 1'b0;
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_sum", sum, 0);
        check("abort_cout", cout, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        idle(W + 3);
        run_op(8'h80, 8'h80, 1'b0, 1'b0, 0);
        idle(2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/serial_add_unit.md
Name: serial_add_unit

Overview:
Bit-serial adder built around the team's single-bit full-adder cell, instantiated once with ports s, c, x, y, z. Consumes the cell's sum and carry outputs each clock and registers the carry back into its z input. A controller loads two WIDTH-bit operands, streams them LSB-first through the cell, assembles the result, and reports completion with a one-cycle done pulse. Serves as the area-minimal adder stage for narrow-datapath blocks.

Parameters:
WIDTH, 8, operand and result width in bits; legal range 2..32.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
start  input  1  request; sampled only in IDLE or DONE
a  input  WIDTH  operand A; captured on the accepted start edge
b  input  WIDTH  operand B; captured on the accepted start edge
cin  input  1  carry-in; captured on the accepted start edge
busy  output  1  high while in SHIFT
done  output  1  one-cycle completion pulse
sum  output  WIDTH  result, registered, held until the next completion
cout  output  1  final carry-out, registered, held with sum

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE; busy=0, done=0, sum=0, cout=0; operand shift registers, result shift register, carry flop and bit counter all cleared. Reset mid-operation aborts the addition with no done pulse. After rst_n deasserts, the first start is honoured on the next rising edge.
- States:
  - IDLE: start=1 -> SHIFT. Load sa<=a, sb<=b, carry<=cin, cnt<=0.
  - SHIFT: each edge:
    - drive cell with x=sa[0], y=sb[0], z=carry
    - carry<=c
    - result shift register <= {s, result[WIDTH-1:1]}
    - sa, sb shift right by one
    - cnt<=cnt+1
    - when cnt==WIDTH-1 on that edge -> DONE; on the same edge sum<={s, result[WIDTH-1:1]} and cout<=c.
  - DONE: done=1 for exactly this one cycle, then -> IDLE. start=1 in DONE is accepted exactly as in IDLE (load, -> SHIFT), giving back-to-back operation with no idle gap.
- start in SHIFT is ignored; operands are not re-sampled and the count is not restarted.
- a, b and cin may change freely after the accepting edge without effect.
- Latency:
  - start sampled at edge E0.
  - WIDTH shift edges E1..EWIDTH.
  - done high in the cycle after EWIDTH, i.e. WIDTH+1 edges after E0.
  - Throughput: one addition per WIDTH+1 cycles.
- busy=1 exactly in SHIFT (WIDTH cycles per operation); busy and done are never both high.
- sum and cout update only on the final shift edge; they are stable at all other times, including throughout a subsequent operation.
- Arithmetic: {cout,sum} = a + b + cin, unsigned, modulo 2^(WIDTH+1); no overflow flag.
- cnt is $clog2(WIDTH) bits wide, plus one bit if WIDTH is a power of two; it never wraps within an operation.
- All outputs are registered, with no combinational path from inputs to outputs.

Test Plan:
- WIDTH=8, a=0x00, b=0x00, cin=0, start 1 cycle -> busy high 8 cycles; done high on cycle 9 after start; sum=0x00, cout=0.
- a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1 (carry ripples through all 8 bits).
- a=0xA5, b=0x5A, cin=1 -> sum=0x00, cout=1. Then a=0x3C, b=0x0F, cin=0 -> sum=0x4B, cout=0; previous result held until the second done.
- start pulsed again 3 cycles into SHIFT with a=0x11, b=0x11 -> ignored; first result completes on schedule and no second done follows.
- start held high continuously with a=0x01, b=0x02, cin=0 -> done every 9th cycle, sum=0x03, cout=0; no idle cycle between done and the next busy.
- rst_n pulled low mid-SHIFT -> busy, done, sum and cout go to 0 immediately; no done pulse; after release, a fresh start a=0x80, b=0x80 gives sum=0x00, cout=1.
